// File: rtl/led_pkg.sv
// LED blink controller shared definitions: mode encodings, FSM state type,
// config-word field layout and the effective half-period helper.
// Pure declarations; no timing or flow control of its own.
package led_pkg;

    // Config word layout (slv_reg)
    localparam int MODE_LSB = 0;
    localparam int MODE_W   = 2;
    localparam int N_LSB    = 4;
    localparam int N_W      = 4;
    localparam int H_LSB    = 8;
    localparam int H_W      = 24;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } state_e;

    // Reload value for the phase timer: max(h, hmin) - 1.
    // hmin is at least 1, so the subtraction never underflows.
    function automatic logic [H_W-1:0] eff_half_m1(input logic [H_W-1:0] h,
                                                   input logic [H_W-1:0] hmin);
        logic [H_W-1:0] he;
        he = (h < hmin) ? hmin : h;
        return he - 1'b1;
    endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Config/status bundle between a register master and the LED blink controller.
// Combinational wiring only; no latency.
// No backpressure: cfg_load is a fire-and-forget strobe.
// Signals: slv_reg (config word), cfg_load (sample strobe),
//          led_out / busy / done (registered status from the controller).
interface led_blink_ctrl_if;
    import led_pkg::*;

    logic [31:0] slv_reg;
    logic        cfg_load;
    logic        led_out;
    logic        busy;
    logic        done;

    modport master (
        output slv_reg,
        output cfg_load,
        input  led_out,
        input  busy,
        input  done
    );

    modport slave (
        input  slv_reg,
        input  cfg_load,
        output led_out,
        output busy,
        output done
    );

endinterface

// File: rtl/led_phase_timer.sv
// Loadable down-counter that times one HIGH or LOW phase; expire when count is 0.
// Load takes effect on the next edge; expire is decoded from the registered count.
// No backpressure; load has priority over decrement, and the count parks at 0.
// Ports: clk, rst (async active-high), load/load_val (start a phase),
//        en (count down this cycle), expire (count has reached 0).
module led_phase_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/led_blink_ctrl.sv
// LED controller: OFF / ON / BLINK / BURST sequences with programmable half-period.
// Outputs respond on the edge that samples cfg_load; all outputs are registered.
// No backpressure: a new cfg_load always aborts whatever sequence is running.
// Ports: clk, rst (async active-high), bus (slave modport: slv_reg, cfg_load in;
//        led_out, busy, done out).
module led_blink_ctrl
    import led_pkg::*;
#(
    parameter int HALF_MIN = 1
) (
    input  logic               clk,
    input  logic               rst,
    led_blink_ctrl_if.slave    bus
);

    localparam logic [H_W-1:0] HMIN = (HALF_MIN < 1) ? H_W'(1) : H_W'(HALF_MIN);

    // Decoded fields of the incoming config word
    mode_e          cfg_mode;
    logic [N_W-1:0] cfg_n;
    logic [H_W-1:0] cfg_he_m1;
    logic [1:0]     unused_rsvd;

    assign cfg_mode    = mode_e'(bus.slv_reg[MODE_LSB +: MODE_W]);
    assign cfg_n       = bus.slv_reg[N_LSB +: N_W];
    assign cfg_he_m1   = eff_half_m1(bus.slv_reg[H_LSB +: H_W], HMIN);
    assign unused_rsvd = bus.slv_reg[3:2];

    // Latched configuration and sequence state
    state_e         state;
    mode_e          mode_q;
    logic [H_W-1:0] he_m1_q;
    logic [N_W-1:0] burst_cnt;
    logic           led_q;
    logic           busy_q;
    logic           done_q;

    // Phase timer: restarted by every cfg_load and at every phase boundary.
    logic           tmr_expire;
    logic           tmr_load;
    logic [H_W-1:0] tmr_load_val;
    logic           in_seq;

    assign in_seq       = (state != ST_IDLE);
    assign tmr_load     = bus.cfg_load || (in_seq && tmr_expire);
    assign tmr_load_val = bus.cfg_load ? cfg_he_m1 : he_m1_q;

    led_phase_timer #(.W(H_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (in_seq),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_OFF;
            he_m1_q   <= '0;
            burst_cnt <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.cfg_load) begin
            // A new config always wins, including over a burst that would
            // finish on this very edge, so done stays low here unless the
            // new config is itself an empty burst.
            mode_q  <= cfg_mode;
            he_m1_q <= cfg_he_m1;
            done_q  <= 1'b0;
            case (cfg_mode)
                MODE_OFF: begin
                    state     <= ST_IDLE;
                    led_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    burst_cnt <= '0;
                end
                MODE_ON: begin
                    state     <= ST_IDLE;
                    led_q     <= 1'b1;
                    busy_q    <= 1'b0;
                    burst_cnt <= '0;
                end
                MODE_BLINK: begin
                    state     <= ST_HIGH;
                    led_q     <= 1'b1;
                    busy_q    <= 1'b1;
                    burst_cnt <= '0;
                end
                default: begin // MODE_BURST
                    if (cfg_n == '0) begin
                        // Empty burst: completes immediately, LED untouched.
                        state     <= ST_IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        burst_cnt <= '0;
                    end else begin
                        state     <= ST_HIGH;
                        led_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        burst_cnt <= cfg_n;
                    end
                end
            endcase
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_HIGH: begin
                    if (tmr_expire) begin
                        state <= ST_LOW;
                        led_q <= 1'b0;
                    end
                end
                ST_LOW: begin
                    if (tmr_expire) begin
                        if ((mode_q == MODE_BURST) && (burst_cnt == N_W'(1))) begin
                            state     <= ST_IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            burst_cnt <= '0;
                        end else begin
                            if (mode_q == MODE_BURST) begin
                                burst_cnt <= burst_cnt - 1'b1;
                            end
                            state <= ST_HIGH;
                            led_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE holds the last static level.
                end
            endcase
        end
    end

    assign bus.led_out = led_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Self-checking bench for led_blink_ctrl: directed scenarios plus random configs,
// checked every cycle against a pattern model derived from elapsed time since load.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_led_blink_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_blink_ctrl_if bus ();

    led_blink_ctrl #(.HALF_MIN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: current config and cycles elapsed since it was loaded.
    int   m_mode;
    int   m_n;
    int   m_he;
    int   m_t;
    logic m_idle_led;

    function automatic logic [31:0] mk(input int mode, input int n, input int h);
        logic [31:0] w;
        w        = '0;
        w[1:0]   = mode[1:0];
        w[7:4]   = n[3:0];
        w[31:8]  = h[23:0];
        return w;
    endfunction

    // Expected {led_out, busy, done} for the sample m_t cycles after the load edge.
    function automatic logic [2:0] model_out();
        int span;
        case (m_mode)
            0: return 3'b000;
            1: return 3'b100;
            2: return {((m_t / m_he) % 2) == 0, 2'b10};
            default: begin
                if (m_n == 0) begin
                    return {m_idle_led, 1'b0, (m_t == 0)};
                end
                span = 2 * m_n * m_he;
                if (m_t < span) return {((m_t / m_he) % 2) == 0, 2'b10};
                if (m_t == span) return 3'b001;
                return 3'b000;
            end
        endcase
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_n        = 0;
        m_he       = 1;
        m_t        = 1000;
        m_idle_led = 1'b0;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        logic [2:0] e;
        e = model_out();
        check({tag, ".led"},  bus.led_out, e[2]);
        check({tag, ".busy"}, bus.busy,    e[1]);
        check({tag, ".done"}, bus.done,    e[0]);
    endtask

    // One clock: capture what the DUT will sample, advance the model, check.
    task automatic tick(input string tag);
        logic        ld;
        logic [31:0] w;
        logic [2:0]  prev;
        int          h;
        ld   = bus.cfg_load;
        w    = bus.slv_reg;
        prev = model_out();
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (ld) begin
            m_idle_led = prev[2];
            m_mode     = int'(w[1:0]);
            m_n        = int'(w[7:4]);
            h          = int'(w[31:8]);
            m_he       = (h < 1) ? 1 : h;
            m_t        = 0;
        end else begin
            m_t++;
        end
        bus.cfg_load = 1'b0;
        check_all(tag);
    endtask

    task automatic load(input logic [31:0] w, input string tag);
        bus.slv_reg  = w;
        bus.cfg_load = 1'b1;
        tick(tag);
    endtask

    initial begin
        int mode, n, h, hold;

        model_reset();
        rst          = 1'b1;
        bus.cfg_load = 1'b0;
        bus.slv_reg  = mk(2, 0, 3);
        tick("reset");
        tick("reset");
        rst = 1'b0;

        // Load on the first edge after reset release: BLINK H=3
        load(mk(2, 0, 3), "blink_h3");
        repeat (13) tick("blink_h3");

        // slv_reg wiggles without cfg_load must not disturb the waveform
        for (int i = 0; i < 8; i++) begin
            bus.slv_reg = $urandom;
            tick("no_load");
        end

        // Asynchronous reset mid-BLINK: outputs fall before the next edge
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        tick("in_rst");
        rst = 1'b0;
        bus.slv_reg = mk(1, 0, 1);
        repeat (4) tick("post_rst_idle");

        // BURST N=2 H=2: 1,1,0,0,1,1,0,0 then done and idle
        load(mk(3, 2, 2), "burst_n2");
        repeat (11) tick("burst_n2");

        // BURST N=0: immediate single done pulse, no LED activity
        load(mk(3, 0, 5), "burst_n0");
        repeat (3) tick("burst_n0");

        // BLINK H=0 behaves as HALF_MIN=1: toggles every cycle
        load(mk(2, 0, 0), "blink_h0");
        repeat (6) tick("blink_h0");

        // Abort BURST N=3 H=4 mid-HIGH with ON: steady 1, no done
        load(mk(3, 3, 4), "abort_burst");
        repeat (2) tick("abort_burst");
        load(mk(1, 0, 0), "abort_on");
        repeat (30) tick("abort_on");

        // New config on the very edge that would end a burst: no done pulse
        load(mk(3, 1, 2), "coincide");
        repeat (3) tick("coincide");
        load(mk(0, 0, 0), "coincide_off");
        repeat (3) tick("coincide_off");

        // Randomised configs with random dwell times and aborts
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 3));
            h    = int'($urandom_range(0, 4));
            load(mk(mode, n, h), "rand_load");
            hold = int'($urandom_range(1, 2 * (n + 1) * (h + 1) + 4));
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 3) == 0) bus.slv_reg = $urandom;
                tick("rand_run");
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
LED_BLINK_CTRL -- requirements
Module: led_blink_ctrl

Interface
REQ-001 Parameter HALF_MIN, default 1: minimum half-period in clk cycles; smaller programmed values are clamped up to it.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 slv_reg  input  32  config word: [1:0] mode (00 OFF, 01 ON, 10 BLINK, 11 BURST); [7:4] burst count N; [31:8] half-period H in clk cycles.
REQ-005 cfg_load  input  1  single-cycle strobe; slv_reg is sampled only on cycles where cfg_load=1.
REQ-006 led_out  output  1  registered LED drive.
REQ-007 busy  output  1  high while BLINK or BURST sequence is active.
REQ-008 done  output  1  one-cycle pulse when a BURST sequence completes.

Function
REQ-009 The FSM SHALL have states IDLE, HIGH, LOW; all outputs SHALL be registered.
REQ-010 On cfg_load=1 at edge k, mode, N and H SHALL be latched; slv_reg changes without cfg_load SHALL have no effect.
REQ-011 Effective half-period He SHALL be max(H, HALF_MIN); H=0 SHALL behave as HALF_MIN.
REQ-012 Mode OFF: from edge k+1, led_out=0, busy=0, state IDLE.
REQ-013 Mode ON: from edge k+1, led_out=1, busy=0, state IDLE.
REQ-014 Mode BLINK: from edge k+1 led_out=1 for exactly He cycles (HIGH), then 0 for He cycles (LOW), repeating indefinitely; busy=1 throughout.
REQ-015 Mode BURST, N>=1: N HIGH/LOW pairs of He cycles each, starting edge k+1; on the edge ending the Nth LOW phase, state->IDLE, busy->0, done=1 for exactly one cycle, led_out=0.
REQ-016 Mode BURST, N=0: no LED activity; done=1 for the single cycle after edge k; busy stays 0.
REQ-017 cfg_load while busy SHALL abort the running sequence and apply the new config from edge k+1 with no extra idle cycle; the aborted burst SHALL NOT pulse done.
REQ-018 cfg_load coincident with the edge that would end a burst: the new config wins; done SHALL NOT pulse.
REQ-019 Phase counter SHALL be 24 bits, load He-1 at phase start, decrement each cycle, switch phase at 0; no wrap beyond 24 bits.
REQ-020 Burst counter SHALL be 4 bits, load N, decrement at end of each LOW phase.
REQ-021 In IDLE, led_out SHALL hold the level set by the last OFF/ON config (0 after BURST completion).

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, led_out=0, busy=0, done=0, counters 0, latched mode OFF, regardless of clk.
REQ-023 Reset asserted mid-sequence SHALL abandon it; after release the block SHALL stay idle until the next cfg_load.
REQ-024 cfg_load on the first edge after rst deassertion SHALL be honoured.

Structure
REQ-025 Package led_pkg SHALL hold mode encodings, FSM state type, and slv_reg field positions/widths (MODE, N, H).
REQ-026 One sub-module, led_phase_timer (24-bit loadable down-counter with expire flag), SHALL implement the phase timing; the FSM and burst counter live in led_blink_ctrl.

Verification
REQ-027 Reset: assert rst mid-BLINK asynchronously -> led_out, busy, done drop to 0 before next clk edge; no activity until cfg_load.
REQ-028 BLINK H=3: cfg_load -> led_out pattern 1,1,1,0,0,0 repeating from k+1; busy=1 continuously.
REQ-029 BURST N=2, H=2: -> led_out 1,1,0,0,1,1,0,0 then 0; done pulse exactly one cycle at the edge ending the 8th cycle; busy low same edge.
REQ-030 BURST N=0 and BLINK H=0 (HALF_MIN=1) -> single done pulse at k+1 with no LED toggle; BLINK toggles every cycle.
REQ-031 Abort: cfg_load ON during BURST N=3, H=4 mid-HIGH -> led_out=1 steady from k+1, busy=0, no done pulse.
REQ-032 slv_reg changed without cfg_load during BLINK -> waveform unchanged.
